// File: rtl/mem_nzlat_pipe.sv
// rtl/mem_nzlat_pipe.sv - in-order memory model with bounded random/fixed response latency
//
// Word-addressed memory behind a request/response handshake. Every accepted
// request is given a latency and queued; transactions retire strictly in
// acceptance order, and the memory operation happens at retire time. Reads
// therefore observe exactly the writes accepted before them.
//
// Ports
//   clk        : clock
//   rst_n      : asynchronous active-low reset
//   req_valid  : request valid                 req_ready : request accept (out)
//   req_write  : 1 = write, 0 = read           req_addr  : word address
//   req_wdata  : write data                    req_wstrb : byte enables
//   rsp_valid  : response valid (out)          rsp_ready : response accept
//   rsp_write  : response is a write ack (out) rsp_rdata : read data (out)

module mem_nzlat_pipe #(
   parameter int          DATA_WIDTH      = 32,
   parameter int          DEPTH           = 1024,
   parameter int          MIN_LATENCY     = 1,
   parameter int          MAX_LATENCY     = 5,
   parameter int          MAX_OUTSTANDING = 4,
   parameter int          RANDOM_LATENCY  = 1,
   parameter logic [15:0] LFSR_SEED       = 16'hACE1,
   localparam int         ADDR_WIDTH      = $clog2(DEPTH),
   localparam int         STRB_WIDTH      = DATA_WIDTH / 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   input  logic [STRB_WIDTH-1:0] req_wstrb,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic                  rsp_write,
   output logic [DATA_WIDTH-1:0] rsp_rdata
);

   localparam int          CNT_W     = $clog2(MAX_OUTSTANDING + 1);
   localparam int          LAT_RANGE = MAX_LATENCY - MIN_LATENCY + 1;
   localparam logic [15:0] SEED      = (LFSR_SEED == 16'h0000) ? 16'hACE1 : LFSR_SEED;

   // Tracking queue: entry 0 is always the oldest (head); retire shifts down.
   logic [CNT_W-1:0]      r_count;
   logic                  r_q_op    [MAX_OUTSTANDING];
   logic [ADDR_WIDTH-1:0] r_q_addr  [MAX_OUTSTANDING];
   logic [DATA_WIDTH-1:0] r_q_wdata [MAX_OUTSTANDING];
   logic [STRB_WIDTH-1:0] r_q_wstrb [MAX_OUTSTANDING];
   logic [7:0]            r_q_cnt   [MAX_OUTSTANDING];

   logic                  w_q_op_nxt    [MAX_OUTSTANDING];
   logic [ADDR_WIDTH-1:0] w_q_addr_nxt  [MAX_OUTSTANDING];
   logic [DATA_WIDTH-1:0] w_q_wdata_nxt [MAX_OUTSTANDING];
   logic [STRB_WIDTH-1:0] w_q_wstrb_nxt [MAX_OUTSTANDING];
   logic [7:0]            w_q_cnt_nxt   [MAX_OUTSTANDING];

   logic [15:0]           r_lfsr;
   logic                  r_rsp_valid;
   logic                  r_rsp_write;
   logic [DATA_WIDTH-1:0] r_rsp_rdata;
   logic [DATA_WIDTH-1:0] r_mem [DEPTH];

   logic [CNT_W:0]        w_outstanding;
   logic                  w_accept;
   logic                  w_retire;
   logic [CNT_W-1:0]      w_tail;
   logic [7:0]            w_lat;
   logic                  w_lfsr_fb;

   // The held response occupies a slot until it is actually popped, so a
   // pop in this cycle only frees the slot from the next cycle on.
   assign w_outstanding = {1'b0, r_count} + (CNT_W + 1)'(r_rsp_valid);
   assign req_ready     = (w_outstanding < (CNT_W + 1)'(MAX_OUTSTANDING));
   assign w_accept      = req_valid & req_ready;

   // Head retires once its countdown has expired and the response register
   // is free (empty, or being drained this very cycle).
   assign w_retire = (r_count != '0) && (r_q_cnt[0] == 8'd0) &&
                     (!r_rsp_valid || rsp_ready);

   // Slot the new request lands in, after any shift caused by a retire.
   assign w_tail = r_count - CNT_W'(w_retire);

   assign w_lat = (RANDOM_LATENCY != 0) ?
                  8'(16'(MIN_LATENCY) + (r_lfsr % 16'(LAT_RANGE))) :
                  8'(MAX_LATENCY);

   // Fibonacci LFSR, taps 16/14/13/11, shifting toward bit 0.
   assign w_lfsr_fb = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];

   always_comb begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
         w_q_op_nxt[i]    = r_q_op[i];
         w_q_addr_nxt[i]  = r_q_addr[i];
         w_q_wdata_nxt[i] = r_q_wdata[i];
         w_q_wstrb_nxt[i] = r_q_wstrb[i];
         w_q_cnt_nxt[i]   = r_q_cnt[i];
         if (w_retire) begin
            // The top slot picks up slot 0's stale contents; it is beyond
            // the new count, so its value is never looked at.
            w_q_op_nxt[i]    = r_q_op[(i + 1) % MAX_OUTSTANDING];
            w_q_addr_nxt[i]  = r_q_addr[(i + 1) % MAX_OUTSTANDING];
            w_q_wdata_nxt[i] = r_q_wdata[(i + 1) % MAX_OUTSTANDING];
            w_q_wstrb_nxt[i] = r_q_wstrb[(i + 1) % MAX_OUTSTANDING];
            w_q_cnt_nxt[i]   = r_q_cnt[(i + 1) % MAX_OUTSTANDING];
         end
         if (w_q_cnt_nxt[i] != 8'd0) begin
            w_q_cnt_nxt[i] = w_q_cnt_nxt[i] - 8'd1;
         end
         if (w_accept && (CNT_W'(i) == w_tail)) begin
            w_q_op_nxt[i]    = req_write;
            w_q_addr_nxt[i]  = req_addr;
            w_q_wdata_nxt[i] = req_wdata;
            w_q_wstrb_nxt[i] = req_wstrb;
            w_q_cnt_nxt[i]   = w_lat - 8'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
         for (int i = 0; i < MAX_OUTSTANDING; i++) begin
            r_q_op[i]    <= 1'b0;
            r_q_addr[i]  <= '0;
            r_q_wdata[i] <= '0;
            r_q_wstrb[i] <= '0;
            r_q_cnt[i]   <= 8'd0;
         end
      end else begin
         r_count <= r_count + CNT_W'(w_accept) - CNT_W'(w_retire);
         for (int i = 0; i < MAX_OUTSTANDING; i++) begin
            r_q_op[i]    <= w_q_op_nxt[i];
            r_q_addr[i]  <= w_q_addr_nxt[i];
            r_q_wdata[i] <= w_q_wdata_nxt[i];
            r_q_wstrb[i] <= w_q_wstrb_nxt[i];
            r_q_cnt[i]   <= w_q_cnt_nxt[i];
         end
      end
   end

   // Advances only on accepted requests so the latency sequence depends on
   // the request stream alone, not on idle cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_lfsr <= SEED;
      end else if (w_accept) begin
         r_lfsr <= {w_lfsr_fb, r_lfsr[15:1]};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (w_retire && r_q_op[0]) begin
         for (int b = 0; b < STRB_WIDTH; b++) begin
            if (r_q_wstrb[0][b]) begin
               r_mem[r_q_addr[0]][8*b +: 8] <= r_q_wdata[0][8*b +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rsp_valid <= 1'b0;
         r_rsp_write <= 1'b0;
         r_rsp_rdata <= '0;
      end else if (w_retire) begin
         r_rsp_valid <= 1'b1;
         r_rsp_write <= r_q_op[0];
         r_rsp_rdata <= r_q_op[0] ? '0 : r_mem[r_q_addr[0]];
      end else if (r_rsp_valid && rsp_ready) begin
         r_rsp_valid <= 1'b0;
         r_rsp_write <= 1'b0;
         r_rsp_rdata <= '0;
      end
   end

   assign rsp_valid = r_rsp_valid;
   assign rsp_write = r_rsp_write;
   assign rsp_rdata = r_rsp_rdata;

endmodule

// File: doc/mem_nzlat_pipe.md
MEM_NZLAT_PIPE -- requirements
Module: mem_nzlat_pipe

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: data word width in bits; multiple of 8.
REQ-002 SHALL have parameter DEPTH, default 1024: number of words; power of two; ADDR_WIDTH = $clog2(DEPTH).
REQ-003 SHALL have parameter MIN_LATENCY, default 1: minimum request-to-response latency in cycles; range 1 to MAX_LATENCY.
REQ-004 SHALL have parameter MAX_LATENCY, default 5: maximum latency in cycles; at most 255.
REQ-005 SHALL have parameter MAX_OUTSTANDING, default 4: maximum number of in-flight transactions; range 1 to 16.
REQ-006 SHALL have parameter RANDOM_LATENCY, default 1: 1 selects LFSR-random latency, 0 selects fixed latency.
REQ-007 SHALL have parameter LFSR_SEED, default 16'hACE1: initial LFSR value; a value of 0 is replaced by 16'hACE1.
REQ-008 SHALL have ports: clk (in, 1, clock) and rst_n (in, 1, reset). There is one clock; reset is asynchronous and active-low.
REQ-009 SHALL have request ports, all inputs unless stated:
- req_valid (1): request valid.
- req_ready (out, 1): request accept.
- req_write (1): 1 = write, 0 = read.
- req_addr (ADDR_WIDTH): word address.
- req_wdata (DATA_WIDTH): write data.
- req_wstrb (DATA_WIDTH/8): byte enables.
REQ-010 SHALL have response ports, all outputs unless stated:
- rsp_valid (1): response valid.
- rsp_ready (in, 1): response accept.
- rsp_write (1): response is a write acknowledge.
- rsp_rdata (DATA_WIDTH): read data.

Function
REQ-011 SHALL accept a request on every rising clk edge where req_valid and req_ready are both 1; this edge is the acceptance edge.
REQ-012 SHALL drive req_ready = 1 iff outstanding < MAX_OUTSTANDING. Outstanding counts queued entries plus the held response, from registered state only; a response popped in the same cycle does not free a slot until the next cycle.
REQ-013 SHALL complete transactions strictly in acceptance order, using a tracking queue of MAX_OUTSTANDING entries. Each entry holds op, addr, wdata, wstrb and a latency countdown.
REQ-014 SHALL assign each request a latency L at acceptance:
- RANDOM_LATENCY = 0: L = MAX_LATENCY.
- RANDOM_LATENCY = 1: L = MIN_LATENCY + (lfsr mod (MAX_LATENCY - MIN_LATENCY + 1)).
REQ-015 SHALL use a 16-bit Fibonacci LFSR with taps 16, 14, 13, 11. It advances once per accepted request only and is deterministic for a given seed.
REQ-016 SHALL load the countdown with L-1 at acceptance and decrement every entry's countdown each cycle, saturating at 0.
REQ-017 SHALL retire the head entry at a clock edge when its countdown is 0 and the response register is empty or being popped (rsp_valid & rsp_ready) in that cycle.
REQ-018 SHALL perform the memory operation at the retire edge:
- Read: mem[addr] is captured into rsp_rdata.
- Write: each byte lane i with wstrb[i] = 1 is committed; rsp_rdata = 0.
REQ-019 SHALL assert rsp_valid exactly L cycles after the acceptance edge when there is no backpressure and no older pending entry. Any backpressure or blocking only adds delay; ordering is never violated.
REQ-020 SHALL hold rsp_valid, rsp_write and rsp_rdata stable while rsp_valid = 1 and rsp_ready = 0.
REQ-021 SHALL drive rsp_rdata = 0 and rsp_write = 0 whenever rsp_valid = 0.
REQ-022 SHALL make a read see all earlier-accepted writes and no later-accepted writes, because operations execute at in-order retire.
REQ-023 SHALL treat a write with wstrb = 0 as leaving memory unchanged while still producing a write acknowledge.
REQ-024 SHALL allow acceptance and retire in the same cycle, with outstanding updated by +1, -1 or 0 as appropriate.
REQ-025 SHALL ignore req_write, req_addr, req_wdata and req_wstrb when req_valid & req_ready = 0.

Reset
REQ-026 SHALL, while rst_n = 0, immediately and asynchronously set:
- queue empty and outstanding = 0;
- rsp_valid = 0, rsp_write = 0, rsp_rdata = 0;
- req_ready = 1;
- lfsr = LFSR_SEED (or 16'hACE1 if LFSR_SEED = 0);
- all memory words = 0.
REQ-027 SHALL discard in-flight transactions when reset is asserted mid-operation. Uncommitted writes are never applied and no response is produced after reset is released.

Verification
REQ-028 Fixed latency (RANDOM_LATENCY = 0, MAX_LATENCY = 3): write addr 5, data 0xDEADBEEF, wstrb 0xF, rsp_ready = 1 -> rsp_valid with rsp_write = 1 exactly 3 cycles after acceptance. Then read addr 5 -> rsp_rdata = 0xDEADBEEF, rsp_write = 0, 3 cycles after acceptance.
REQ-029 Byte strobes: write 0x11223344 to addr 7 with wstrb 0xF, then write 0xAABBCCDD with wstrb 0x5, then read addr 7 -> 0x11BB33DD.
REQ-030 Full and backpressure (MAX_OUTSTANDING = 4, rsp_ready = 0): issue 6 back-to-back reads -> exactly 4 accepted and req_ready = 0. Then rsp_ready = 1 -> 4 responses in order, the remaining 2 accepted, 6 responses total, none dropped or duplicated.
REQ-031 Random latency (MIN 1, MAX 5, seed 0xACE1): 200 random reads and writes compared against a reference model -> every latency in [1,5], responses in order, all data correct. Rerun with the same seed -> cycle-identical trace.
REQ-032 Read after write while in flight: write addr 9 = 0x1234 immediately followed by read addr 9, random latency -> read returns 0x1234.
REQ-033 Reset mid-operation: 2 writes in flight, then rst_n pulse low -> no rsp_valid afterwards, req_ready = 1, and reads of those addresses return 0.
